// File: rtl/bw_pkg.sv
// Shared types and constants for the black/white threshold stream stage.
package bw_pkg;

  localparam int unsigned PIX_W = 8;
  localparam logic [PIX_W-1:0] BW_WHITE = 8'hFF;
  localparam logic [PIX_W-1:0] BW_BLACK = 8'h00;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } bw_state_e;

endpackage

// File: rtl/bw_threshold_stream_if.sv
// Pixel stream handshake bundle: luma in, black/white pixel plus line/frame markers out.
interface bw_threshold_stream_if;
  import bw_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_luma;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_eol;
  logic             out_eof;

  modport slave (
    input  in_valid, in_luma, in_sof, out_ready,
    output in_ready, out_valid, out_pixel, out_eol, out_eof
  );

  modport master (
    output in_valid, in_luma, in_sof, out_ready,
    input  in_ready, out_valid, out_pixel, out_eol, out_eof
  );
endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry registered skid buffer: output register plus one overflow slot; ready is registered.
module stream_skid_buf #(
  parameter int unsigned DataW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DataW-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DataW-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             push;

  always_comb begin
    push         = in_valid_i && ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      // Skid contents always drain before new input, preserving order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/bw_threshold_stream.sv
// Luma-to-black/white threshold stage with frame position tracking and resync detection.
// Optional BW_WHITE_COUNT_EN adds a per-frame white pixel total on white_count.
module bw_threshold_stream
  import bw_pkg::*;
#(
  parameter int unsigned      IMG_W   = 320,
  parameter int unsigned      IMG_H   = 240,
  parameter logic [PIX_W-1:0] THR_RST = 8'd128
) (
  input  logic                  clk,
  input  logic                  rst,
  bw_threshold_stream_if.slave  px_if,
  input  logic                  thr_wr,
  input  logic [PIX_W-1:0]      thr_data,
`ifdef BW_WHITE_COUNT_EN
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] white_count,
`endif
  output logic                  frame_err
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  bw_state_e        state_q;
  logic [XW-1:0]    x_q, px_x;
  logic [YW-1:0]    y_q, px_y;
  logic [PIX_W-1:0] thr_active_q, thr_pending_q, thr_eff, pix;
  logic             frame_err_q;
  logic             in_ready, accept, sof_acc, emit, eol, eof, resync;
  logic [PIX_W+1:0] skid_out;

  always_comb begin
    accept  = px_if.in_valid && in_ready;
    sof_acc = accept && px_if.in_sof;
    emit    = accept && ((state_q == ACTIVE) || px_if.in_sof);
    // A frame-start pixel already uses the threshold it latches for its frame.
    thr_eff = px_if.in_sof ? (thr_wr ? thr_data : thr_pending_q) : thr_active_q;
    pix     = (px_if.in_luma >= thr_eff) ? BW_WHITE : BW_BLACK;
    px_x    = px_if.in_sof ? '0 : x_q;
    px_y    = px_if.in_sof ? '0 : y_q;
    eol     = (px_x == XLast);
    eof     = eol && (px_y == YLast);
    resync  = sof_acc && (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_SOF;
      x_q           <= '0;
      y_q           <= '0;
      thr_active_q  <= THR_RST;
      thr_pending_q <= THR_RST;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= resync;
      if (thr_wr) thr_pending_q <= thr_data;
      if (sof_acc) thr_active_q <= thr_eff;
      if (emit) begin
        if (eof) begin
          x_q     <= '0;
          y_q     <= '0;
          state_q <= WAIT_SOF;
        end else if (eol) begin
          x_q     <= '0;
          y_q     <= px_y + 1'b1;
          state_q <= ACTIVE;
        end else begin
          x_q     <= px_x + 1'b1;
          y_q     <= px_y;
          state_q <= ACTIVE;
        end
      end
    end
  end

  stream_skid_buf #(
    .DataW (PIX_W + 2)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (emit),
    .in_ready_o  (in_ready),
    .in_data_i   ({pix, eol, eof}),
    .out_valid_o (px_if.out_valid),
    .out_ready_i (px_if.out_ready),
    .out_data_o  (skid_out)
  );

  assign px_if.in_ready  = in_ready;
  assign px_if.out_pixel = skid_out[PIX_W+1:2];
  assign px_if.out_eol   = skid_out[1];
  assign px_if.out_eof   = skid_out[0];
  assign frame_err       = frame_err_q;

`ifdef BW_WHITE_COUNT_EN
  localparam int unsigned CW = $clog2(IMG_W*IMG_H+1);

  logic [CW-1:0] wcnt_q, white_count_q;
  logic          pop, is_white;

  assign pop      = px_if.out_valid && px_if.out_ready;
  assign is_white = (px_if.out_pixel == BW_WHITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q        <= '0;
      white_count_q <= '0;
    end else if (resync) begin
      wcnt_q <= '0;
    end else if (pop) begin
      if (px_if.out_eof) begin
        white_count_q <= wcnt_q + CW'(is_white);
        wcnt_q        <= '0;
      end else begin
        wcnt_q <= wcnt_q + CW'(is_white);
      end
    end
  end

  assign white_count = white_count_q;
`endif

endmodule

// File: tb/tb_bw_threshold_stream.sv
// Directed bench for bw_threshold_stream on a 4x2 frame; white_count checks when BW_WHITE_COUNT_EN.
module tb_bw_threshold_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       thr_wr;
  logic [7:0] thr_data;
  logic       frame_err;
`ifdef BW_WHITE_COUNT_EN
  logic [3:0] white_count;
`endif

  int checks = 0;
  int errors = 0;

  bw_threshold_stream_if bif ();

  bw_threshold_stream #(
    .IMG_W   (4),
    .IMG_H   (2),
    .THR_RST (8'd128)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .px_if       (bif),
    .thr_wr      (thr_wr),
    .thr_data    (thr_data),
`ifdef BW_WHITE_COUNT_EN
    .white_count (white_count),
`endif
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       sof;
    logic [7:0] luma;
    logic       tw;
    logic [7:0] td;
    logic       ov;
    logic [7:0] px;
    logic       eol;
    logic       eof;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.in_valid  = 1'b0;
    bif.in_sof    = 1'b0;
    bif.in_luma   = 8'd0;
    bif.out_ready = 1'b1;
    thr_wr        = 1'b0;
    thr_data      = 8'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic v, input logic sof, input logic [7:0] luma, input logic ordy);
    @(negedge clk);
    bif.in_valid  = v;
    bif.in_sof    = sof;
    bif.in_luma   = luma;
    bif.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] bp_luma [8];
    logic [7:0] bp_exp  [8];
    int sent, recv, stall_acc;
    bit fire;

    rst = 1'b1;
    idle_inputs();
    do_reset();

    chk("reset in_ready", 32'(bif.in_ready), 32'd1);
    chk("reset out_valid", 32'(bif.out_valid), 32'd0);
    chk("reset out_pixel", 32'(bif.out_pixel), 32'd0);
    chk("reset out_eol", 32'(bif.out_eol), 32'd0);
    chk("reset out_eof", 32'(bif.out_eof), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);

    //              v  sof luma  tw td    ov px     eol eof err
    vecs.push_back('{1, 0, 8'd200, 0, 8'd0, 0, 8'h00, 0, 0, 0}); // discarded before sof
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 0, 8'd0,   0, 8'd0, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 1, 8'd127, 0, 8'd0, 1, 8'h00, 0, 0, 0}); // frame 1, thr 128
    vecs.push_back('{1, 0, 8'd128, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd200, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'h00, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd1,   0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd128, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd127, 0, 8'd0, 1, 8'h00, 1, 1, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 0, 8'h00, 0, 0, 0}); // back to waiting
    vecs.push_back('{1, 1, 8'd100, 0, 8'd0, 1, 8'h00, 0, 0, 0}); // frame 2
    vecs.push_back('{1, 0, 8'd100, 1, 8'd50, 1, 8'h00, 0, 0, 0}); // write 50 mid-frame
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd100, 0, 8'd0, 1, 8'h00, 1, 1, 0});
    vecs.push_back('{1, 1, 8'd100, 0, 8'd0, 1, 8'hFF, 0, 0, 0}); // frame 3, thr 50
    vecs.push_back('{1, 0, 8'd49,  0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd50,  0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'h00, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 1, 8'd255, 1, 8'd255, 1, 8'hFF, 0, 0, 1}); // resync at pixel 5, thr 255
    vecs.push_back('{1, 0, 8'd254, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'h00, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd200, 0, 8'd0, 1, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd255, 0, 8'd0, 1, 8'hFF, 1, 1, 0});
    vecs.push_back('{0, 0, 8'd0,   1, 8'd0, 0, 8'h00, 0, 0, 0}); // thr 0 pending
    vecs.push_back('{1, 1, 8'd0,   0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd1,   0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 0, 8'd0,   0, 8'd0, 1, 8'hFF, 1, 0, 0});

    foreach (vecs[i]) begin
      @(negedge clk);
      bif.in_valid  = vecs[i].v;
      bif.in_sof    = vecs[i].sof;
      bif.in_luma   = vecs[i].luma;
      bif.out_ready = 1'b1;
      thr_wr        = vecs[i].tw;
      thr_data      = vecs[i].td;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(bif.out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d in_ready", i), 32'(bif.in_ready), 32'd1);
      chk($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].err));
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d out_pixel", i), 32'(bif.out_pixel), 32'(vecs[i].px));
        chk($sformatf("vec%0d out_eol", i), 32'(bif.out_eol), 32'(vecs[i].eol));
        chk($sformatf("vec%0d out_eof", i), 32'(bif.out_eof), 32'(vecs[i].eof));
      end
    end

    // Backpressure: out_ready low for 5 cycles under continuous input.
    do_reset();
    bp_luma = '{8'd130, 8'd10, 8'd128, 8'd127, 8'd255, 8'd0, 8'd129, 8'd90};
    bp_exp  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    sent = 0;
    recv = 0;
    stall_acc = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      bif.in_valid  = (sent < 8);
      bif.in_sof    = (sent == 0);
      bif.in_luma   = (sent < 8) ? bp_luma[sent] : 8'd0;
      bif.out_ready = !(cyc >= 2 && cyc < 7);
      fire = bif.in_valid && bif.in_ready;
      if (fire) begin
        sent++;
        if (!bif.out_ready) stall_acc++;
      end
      if (cyc == 6) chk("bp in_ready low in stall", 32'(bif.in_ready), 32'd0);
      if (bif.out_valid && bif.out_ready) begin
        chk($sformatf("bp out%0d pixel", recv), 32'(bif.out_pixel), 32'(bp_exp[recv]));
        chk($sformatf("bp out%0d eol", recv), 32'(bif.out_eol), 32'(recv % 4 == 3));
        chk($sformatf("bp out%0d eof", recv), 32'(bif.out_eof), 32'(recv == 7));
        recv++;
      end
      @(posedge clk);
    end
    chk("bp outputs received", 32'(recv), 32'd8);
    chk("bp inputs accepted", 32'(sent), 32'd8);
    chk("bp beats accepted during stall", 32'(stall_acc), 32'd1);

    // Reset with the skid buffer occupied, then discard-before-sof.
    do_reset();
    send(1, 1, 8'd200, 0);
    send(1, 0, 8'd10, 0);
    chk("mid rst skid full in_ready", 32'(bif.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("mid rst out_valid", 32'(bif.out_valid), 32'd0);
    chk("mid rst in_ready", 32'(bif.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(1, 0, 8'd255, 1);
    chk("post rst no sof out_valid", 32'(bif.out_valid), 32'd0);
    send(1, 1, 8'd255, 1);
    chk("post rst sof out_valid", 32'(bif.out_valid), 32'd1);
    chk("post rst sof out_pixel", 32'(bif.out_pixel), 32'hFF);
    send(0, 0, 8'd0, 1);
    chk("post rst drained out_valid", 32'(bif.out_valid), 32'd0);

`ifdef BW_WHITE_COUNT_EN
    do_reset();
    chk("wc reset", 32'(white_count), 32'd0);
    send(1, 1, 8'd200, 1);
    send(1, 0, 8'd0,   1);
    send(1, 0, 8'd128, 1);
    send(1, 0, 8'd5,   1);
    send(1, 0, 8'd6,   1);
    send(1, 0, 8'd255, 1);
    send(1, 0, 8'd8,   1);
    send(1, 0, 8'd127, 1);
    send(0, 0, 8'd0,   1);
    chk("wc after eof", 32'(white_count), 32'd3);
    send(1, 1, 8'd255, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("wc mid-frame reset", 32'(white_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
